// File: rtl/rv_mc_pkg.sv
// Shared encodings for the multi-cycle RV-subset core: opcodes, function
// fields, the EBREAK word, and the FSM and ALU operation enums.
package rv_mc_pkg;

   localparam logic [6:0]  OP_IMM  = 7'b0010011;
   localparam logic [6:0]  OP      = 7'b0110011;
   localparam logic [6:0]  LUI     = 7'b0110111;
   localparam logic [6:0]  SYSTEM  = 7'b1110011;

   localparam logic [2:0]  F3_ADD  = 3'b000;
   localparam logic [2:0]  F3_XOR  = 3'b100;
   localparam logic [2:0]  F3_OR   = 3'b110;
   localparam logic [2:0]  F3_AND  = 3'b111;

   localparam logic [6:0]  F7_BASE = 7'b0000000;
   localparam logic [6:0]  F7_SUB  = 7'b0100000;

   localparam logic [31:0] EBREAK  = 32'h0010_0073;

   typedef enum logic [1:0] {FETCH, WAIT, EXEC, HALT} state_t;

   typedef enum logic [2:0] {ADD, SUB, XOR, OR, AND, PASSB} alu_op_t;

endpackage

// File: rtl/rv_mc_regfile.sv
// Integer register file: x1..x31 writable, x0 hardwired to zero.
// Two architectural read ports plus a debug read port, one write port.
module rv_mc_regfile #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [4:0]      raddr1,
   input  logic [4:0]      raddr2,
   input  logic [4:0]      dbg_raddr,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2,
   output logic [XLEN-1:0] dbg_rdata
);

   logic [XLEN-1:0] regs [32];

   // Clear all registers on reset; writes aimed at x0 are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && (waddr != 5'd0)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1    = (raddr1    == 5'd0) ? '0 : regs[raddr1];
   assign rdata2    = (raddr2    == 5'd0) ? '0 : regs[raddr2];
   assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];

endmodule

// File: rtl/rv_mc_core.sv
// Multi-cycle RV-subset core: FETCH -> WAIT -> EXEC per instruction, with a
// handshaked instruction fetch, inline decoder/ALU, and sticky halt.
module rv_mc_core import rv_mc_pkg::*; #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'('h8000_0000)
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            retire,
   output logic [XLEN-1:0] retire_pc,
   output logic            halt,
   output logic            illegal,
   input  logic [4:0]      dbg_raddr,
   output logic [XLEN-1:0] dbg_rdata
);

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [31:0]     inst;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [4:0]      rd, rs1, rs2;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic [XLEN-1:0] i_imm, u_imm;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_res;
   alu_op_t         alu_op;
   logic            legal;
   logic            is_ebreak;

   assign opcode = inst[6:0];
   assign rd     = inst[11:7];
   assign funct3 = inst[14:12];
   assign rs1    = inst[19:15];
   assign rs2    = inst[24:20];
   assign funct7 = inst[31:25];

   // Size casts of signed values sign-extend to XLEN for both widths.
   assign i_imm = XLEN'($signed(inst[31:20]));
   assign u_imm = XLEN'($signed({inst[31:12], 12'b0}));

   // The request is combinationally killed during reset so nothing leaks out.
   assign imem_req_valid = (state == FETCH) && !rst;
   assign imem_addr      = pc;

   rv_mc_regfile #(.XLEN(XLEN)) u_rf (
      .clk       (clk),
      .rst       (rst),
      .we        ((state == EXEC) && legal),
      .waddr     (rd),
      .wdata     (alu_res),
      .raddr1    (rs1),
      .raddr2    (rs2),
      .dbg_raddr (dbg_raddr),
      .rdata1    (rs1_val),
      .rdata2    (rs2_val),
      .dbg_rdata (dbg_rdata)
   );

   // Decode: pick the ALU op and B operand; legal covers writeback instructions only.
   always_comb begin
      alu_op    = ADD;
      op_b      = i_imm;
      legal     = 1'b0;
      is_ebreak = 1'b0;
      case (opcode)
         OP_IMM: begin
            legal = 1'b1;
            case (funct3)
               F3_ADD:  alu_op = ADD;
               F3_XOR:  alu_op = XOR;
               F3_OR:   alu_op = OR;
               F3_AND:  alu_op = AND;
               default: legal  = 1'b0;
            endcase
         end
         OP: begin
            op_b = rs2_val;
            if (funct7 == F7_BASE) begin
               legal = 1'b1;
               case (funct3)
                  F3_ADD:  alu_op = ADD;
                  F3_XOR:  alu_op = XOR;
                  F3_OR:   alu_op = OR;
                  F3_AND:  alu_op = AND;
                  default: legal  = 1'b0;
               endcase
            end else if ((funct7 == F7_SUB) && (funct3 == F3_ADD)) begin
               legal  = 1'b1;
               alu_op = SUB;
            end
         end
         LUI: begin
            legal  = 1'b1;
            alu_op = PASSB;
            op_b   = u_imm;
         end
         SYSTEM: is_ebreak = (inst == EBREAK);
         default: ;
      endcase
   end

   // ALU; all arithmetic wraps at XLEN bits.
   always_comb begin
      case (alu_op)
         ADD:     alu_res = rs1_val + op_b;
         SUB:     alu_res = rs1_val - op_b;
         XOR:     alu_res = rs1_val ^ op_b;
         OR:      alu_res = rs1_val | op_b;
         AND:     alu_res = rs1_val & op_b;
         PASSB:   alu_res = op_b;
         default: alu_res = op_b;
      endcase
   end

   // Control FSM; reset takes priority in every state, including mid-WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         inst      <= '0;
         halt      <= 1'b0;
         illegal   <= 1'b0;
         retire    <= 1'b0;
         retire_pc <= '0;
      end else begin
         retire <= 1'b0;
         case (state)
            FETCH: if (imem_req_ready) state <= WAIT;
            WAIT: begin
               if (imem_rsp_valid) begin
                  inst  <= imem_rsp_data;
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (legal) begin
                  pc        <= pc + XLEN'(4);
                  retire    <= 1'b1;
                  retire_pc <= pc;
                  state     <= FETCH;
               end else if (is_ebreak) begin
                  retire    <= 1'b1;
                  retire_pc <= pc;
                  halt      <= 1'b1;
                  state     <= HALT;
               end else begin
                  halt      <= 1'b1;
                  illegal   <= 1'b1;
                  state     <= HALT;
               end
            end
            HALT: ;
            default: state <= HALT;
         endcase
      end
   end

endmodule

// File: doc/rv_mc_core.md
Name: rv_mc_core

Overview:
Parametrised multi-cycle RV-subset integer core. It is the successor to the single-cycle datapath and adds several things that datapath lacks:
- a handshaked instruction-memory interface
- an explicit FETCH/WAIT/EXEC/HALT state machine
- a wider ALU op set, including register-register ops and LUI
- proper x0 handling, EBREAK halt and illegal-instruction detection

It sits at the top of the CPU and talks to an external instruction memory or testbench model.

Parameters:
XLEN, 64, datapath and register width (32 or 64).
RESET_PC, 'h8000_0000 (XLEN bits), PC loaded on reset.

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts request.
imem_addr  output  XLEN  fetch address (current PC).
imem_rsp_valid  input  1  instruction word valid.
imem_rsp_data  input  32  instruction word.
retire  output  1  one-cycle pulse per completed instruction.
retire_pc  output  XLEN  PC of retiring instruction; valid when retire=1.
halt  output  1  sticky; core stopped.
illegal  output  1  sticky; halt was caused by an illegal instruction.
dbg_raddr  input  5  debug register read address.
dbg_rdata  output  XLEN  combinational read of x[dbg_raddr]; x0 reads 0.

Behaviour:
- Reset, sampled at the clock edge:
  - state<=FETCH, pc<=RESET_PC, x1..x31<=0, inst<=0.
  - halt=0, illegal=0, retire=0.
  - imem_req_valid is forced 0 while rst=1.
- Reset wins over every other event in any state, including mid-WAIT. A response arriving after reset, while the core is not in WAIT, is ignored.
- FETCH:
  - imem_req_valid=1 and imem_addr=pc.
  - valid and addr stay stable until imem_req_ready=1.
  - Handshake (valid&ready) moves to WAIT.
  - imem_rsp_valid in FETCH is ignored.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid=1, latch imem_rsp_data into inst and move to EXEC.
  - There is no timeout; the core waits indefinitely.
- EXEC, a single cycle that decodes inst:
  - rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7].
  - OP-IMM (0010011): funct3 000 ADDI, 100 XORI, 110 ORI, 111 ANDI. The immediate is inst[31:20] sign-extended to XLEN.
  - OP (0110011):
    - funct3 000 with funct7 0000000 is ADD; with 0100000 it is SUB.
    - funct3 100 XOR, 110 OR, 111 AND, each requiring funct7=0.
  - LUI (0110111): rd = sign-extend(inst[31:12]<<12) to XLEN.
  - EBREAK (0x00100073): no writeback, state moves to HALT.
  - Anything else is illegal: no writeback, state moves to HALT and illegal is set.
  - Arithmetic wraps modulo 2^XLEN; no overflow flag.
  - Writes to rd=0 are discarded; x0 always reads 0.
- Retirement and PC update:
  - A legal non-EBREAK instruction writes rd at the end of EXEC and sets pc<=pc+4 (wrapping).
  - It asserts retire=1 with retire_pc=old pc for exactly one cycle (the cycle after the EXEC edge), then returns to FETCH.
  - EBREAK also pulses retire. An illegal instruction does not.
- HALT: absorbing until rst; no requests are issued; halt=1.
- Minimum latency is 3 cycles per instruction: FETCH with ready=1, WAIT with a response in the next cycle, then EXEC.
- Register reads in EXEC see all writes from prior instructions; there is no forwarding hazard in a multi-cycle core.

Decomposition:
- Package rv_mc_pkg holds:
  - opcode constants (OP_IMM, OP, LUI, SYSTEM)
  - funct3 and funct7 constants
  - the EBREAK encoding
  - the state enum (FETCH, WAIT, EXEC, HALT)
  - the alu_op enum (ADD, SUB, XOR, OR, AND, PASSB)
- One sub-module, rv_mc_regfile: parametrised by XLEN, 31 writable registers, two async read ports plus the debug read port, one sync write port, synchronous reset to 0, x0 hardwired to 0.
- The ALU and decoder stay inline in rv_mc_core.

Test Plan:
1. Reset: hold rst 2 cycles with ready=1. Required: imem_req_valid=0 during reset; the first cycle after release gives valid=1, addr=0x80000000, halt=0, retire=0.
2. Fetch 0xFFB00093 (addi x1,x0,-5). Required: x1=0xFFFF_FFFF_FFFF_FFFB; retire pulses once with retire_pc=0x80000000; next imem_addr=0x80000004.
3. Fetch addi x1,x0,5 (0x00500093), addi x2,x0,3 (0x00300113), then 0x402081B3 (sub x3,x1,x2). Required: x3=2. Then fetch 0xFFB00093 followed by sub again. Required: x3=0xFFFF_FFFF_FFFF_FFFA (-6 = -5-1 after x1=-5, x2 unchanged=... set x2=1 via 0x00100113 first).
4. Fetch 0x00700013 (addi x0,x0,7). Required: dbg_rdata for x0 is 0 and retire pulses.
5. Hold ready low 3 cycles and rsp_valid 4 cycles late. Required: valid and addr stay stable, there is no retire before the response, and rsp_valid pulses during FETCH are ignored.
6. Fetch 0x00100073. Required: retire, halt=1, illegal=0, no further requests. After reset, fetch 0xFFFFFFFF. Required: halt=1, illegal=1, no retire. Assert rst in WAIT with rsp_valid in the same cycle. Required: no writeback, pc=RESET_PC.
